mem_wb_stage_reg: RTL
=====================

// Module: mem_wb_stage_reg
// PURPOSE
//  Parametrised EX->MEM/WB pipeline register for the RV32I core with a valid/ready handshake,
//  stall (backpressure), flush (bubble insertion) and an optional 1-entry skid buffer.
//  Carries the ALU result, store data, PC+4, PC+imm, immediate, rd address, funct3, byte mask,
//  write-back mux select and memory/RF control from execute to the data-memory / write-back side.
//  Sustains 1 instruction/cycle with no bubbles while out_ready stays high.
// PARAMETERS
//  XLEN      32  datapath width (alu, store, pc, imm fields)
//  RA_W      5   register-file address width
//  WBSEL_W   2   write-back mux select width
//  MASK_W    4   byte-enable mask width (XLEN/8)
//  SKID_EN   1   1: registered in_ready via 1-entry skid buffer; 0: in_ready = out_ready | ~out_valid
// PORTS
//  clk             in   1        core clock, all state on posedge
//  reset           in   1        synchronous, active-high
//  flush           in   1        kill all held entries (branch/trap redirect)
//  in_valid        in   1        execute stage presents an instruction
//  in_ready        out  1        stage can accept this cycle
//  alu_in/store_in/pc_4_in/pc_imm_in/imm_in  in  XLEN each  payload from execute
//  rd_in           in   RA_W     destination register
//  funct3_in       in   3        load/store size/sign
//  mask_in         in   MASK_W   byte mask
//  wb_sel_in       in   WBSEL_W  write-back source select
//  werf_in, mem_en_in, mem_rw_in, load_uns_in  in  1 each  RF write, mem enable, mem read(1)/write(0), unsigned load
//  out_valid       out  1        held entry is a live instruction
//  out_ready       in   1        data memory / WB accepts this cycle
//  alu_out/store_out/pc_4_out/pc_imm_out/imm_out  out  XLEN each  registered payload
//  rd_out, funct3_out, mask_out, wb_sel_out, werf_out, mem_en_out, mem_rw_out, load_uns_out  out  registered
// BEHAVIOUR
//  - Reset (reset=1 at posedge): every output and all skid state cleared to 0, except mem_rw_out=1
//    (read); in_ready=1 the cycle after reset deasserts. funct3_out IS reset.
//  - Accept: in_valid & in_ready at posedge. Emit: out_valid & out_ready at posedge. Latency 1 cycle.
//  - Main reg loads when empty or emitting: source = skid if skid valid, else input.
//  - SKID_EN=1: accept while out_valid & ~out_ready -> write skid; in_ready = ~skid_valid (registered,
//    no combinational path out_ready->in_ready). Skid drains into main on the next emit.
//  - SKID_EN=0: no skid; in_ready combinational; payload holds while out_valid & ~out_ready.
//  - Payload held stable while out_valid & ~out_ready (no change on any output).
//  - Bubble (out_valid=0): werf_out=0, mem_en_out=0, mem_rw_out=1, mask_out=0; data fields don't-care.
//  - Flush: at posedge clears main and skid valid, applies bubble controls; any same-cycle accept is
//    dropped (flush wins). Emit in same cycle still counts as completed for downstream.
//  - reset has priority over flush; reset mid-stall discards both entries.
//  - Order preserved: skid entry always emits before any later-accepted instruction.
// STRUCTURE
//  - rv32_pipe_pkg: WBSEL_ALU/MEM/PC4/IMM encodings, funct3 LB..LHU/SB..SW constants,
//    MEM_READ=1'b1 constant, bubble-control defaults.
//  - Payload concatenated into one vector; one sub-module pipe_skid_buf #(WIDTH, SKID_EN)
//    implements valid/ready/skid/flush generically; this block wraps it and forces bubble controls.
// TESTING
//  - Streaming: in_valid=1, out_ready=1, 8 instrs alu_in=1..8 -> alu_out=1..8 one per cycle, 1-cycle lag.
//  - Stall: out_ready=0 for 3 cycles with alu_in=0xA,0xB -> out holds 0xA, 0xB in skid, in_ready=0;
//    release -> 0xA then 0xB, no loss/duplication.
//  - Flush: two entries held (main+skid), flush=1 -> next cycle out_valid=0, werf_out=0, mem_en_out=0,
//    mem_rw_out=1, in_ready=1; same-cycle in_valid instr not emitted.
//  - Reset mid-stall: entries held, reset=1 -> all outputs 0, mem_rw_out=1, funct3_out=0.
//  - SKID_EN=0: out_ready=0 -> in_ready=0 same cycle; payload stable; out_ready=1 -> in_ready=1 same cycle.
//  - Store passthrough: mem_rw_in=0, mask_in=4'b0011, store_in=0xDEADBEEF -> identical outputs next cycle.

Source files
------------

// File: rtl/rv32_pipe_pkg.sv
// Shared encodings and bubble defaults for the RV32I pipeline stage registers.
package rv32_pipe_pkg;

  // Write-back source select encodings
  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_MEM = 2'd1;
  localparam logic [1:0] WBSEL_PC4 = 2'd2;
  localparam logic [1:0] WBSEL_IMM = 2'd3;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Memory direction: 1 = read, 0 = write
  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  // Control values presented while the stage holds no live instruction
  localparam logic BUBBLE_WERF   = 1'b0;
  localparam logic BUBBLE_MEM_EN = 1'b0;
  localparam logic BUBBLE_MEM_RW = MEM_READ;

  // Handshake state of a two-slot stage, used for readability in debug views
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_MAIN  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Derive occupancy from the two valid bits
  function automatic occ_e occ_of(input logic main_valid, input logic skid_valid);
    if (skid_valid)      return OCC_FULL;
    else if (main_valid) return OCC_MAIN;
    else                 return OCC_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register with optional 1-entry skid buffer and flush.
module pipe_skid_buf
  import rv32_pipe_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output occ_e             occ
);

  logic             r_main_valid;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;

  logic w_accept;
  logic w_load_main;

  // Ready: with a skid it depends only on state, otherwise it passes out_ready through
  always_comb begin
    if (SKID_EN) in_ready = ~r_skid_valid;
    else         in_ready = out_ready | ~r_main_valid;
  end

  assign w_accept    = in_valid & in_ready;
  assign w_load_main = ~r_main_valid | out_ready;
  assign out_valid   = r_main_valid;
  assign out_data    = r_main_data;
  assign occ         = occ_of(r_main_valid, r_skid_valid);

  // Main/skid update; reset beats flush, flush drops any same-cycle accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_data  <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_load_main) begin
      if (r_skid_valid) begin
        // Skid is older than anything on the input; in_ready was low so no accept here
        r_main_valid <= 1'b1;
        r_main_data  <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= w_accept;
        if (w_accept) r_main_data <= in_data;
      end
    end else if (SKID_EN && w_accept) begin
      // Main is stalled: park the new instruction in the skid slot
      r_skid_valid <= 1'b1;
      r_skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/mem_wb_stage_reg.sv
// EX->MEM/WB stage register: packs the payload, delegates handshaking, forces bubble controls.
module mem_wb_stage_reg
  import rv32_pipe_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RA_W    = 5,
  parameter int unsigned WBSEL_W = 2,
  parameter int unsigned MASK_W  = 4,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    alu_in,
  input  logic [XLEN-1:0]    store_in,
  input  logic [XLEN-1:0]    pc_4_in,
  input  logic [XLEN-1:0]    pc_imm_in,
  input  logic [XLEN-1:0]    imm_in,
  input  logic [RA_W-1:0]    rd_in,
  input  logic [2:0]         funct3_in,
  input  logic [MASK_W-1:0]  mask_in,
  input  logic [WBSEL_W-1:0] wb_sel_in,
  input  logic               werf_in,
  input  logic               mem_en_in,
  input  logic               mem_rw_in,
  input  logic               load_uns_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    alu_out,
  output logic [XLEN-1:0]    store_out,
  output logic [XLEN-1:0]    pc_4_out,
  output logic [XLEN-1:0]    pc_imm_out,
  output logic [XLEN-1:0]    imm_out,
  output logic [RA_W-1:0]    rd_out,
  output logic [2:0]         funct3_out,
  output logic [MASK_W-1:0]  mask_out,
  output logic [WBSEL_W-1:0] wb_sel_out,
  output logic               werf_out,
  output logic               mem_en_out,
  output logic               mem_rw_out,
  output logic               load_uns_out
);

  localparam int unsigned PW = 5 * XLEN + RA_W + 3 + MASK_W + WBSEL_W + 4;

  logic [PW-1:0]      w_in_data;
  logic [PW-1:0]      w_out_data;
  logic               w_out_valid;
  occ_e               w_occ;
  logic [MASK_W-1:0]  w_mask;
  logic               w_werf;
  logic               w_mem_en;
  logic               w_mem_rw;

  assign w_in_data = {alu_in, store_in, pc_4_in, pc_imm_in, imm_in, rd_in, funct3_in, mask_in,
                      wb_sel_in, werf_in, mem_en_in, mem_rw_in, load_uns_in};

  pipe_skid_buf #(
    .WIDTH   (PW),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_data),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_data),
    .occ       (w_occ)
  );

  assign {alu_out, store_out, pc_4_out, pc_imm_out, imm_out, rd_out, funct3_out, w_mask,
          wb_sel_out, w_werf, w_mem_en, w_mem_rw, load_uns_out} = w_out_data;

  // Side-effecting controls are masked off whenever the held entry is not live
  always_comb begin
    out_valid  = w_out_valid;
    werf_out   = w_out_valid ? w_werf   : BUBBLE_WERF;
    mem_en_out = w_out_valid ? w_mem_en : BUBBLE_MEM_EN;
    mem_rw_out = w_out_valid ? w_mem_rw : BUBBLE_MEM_RW;
    mask_out   = w_out_valid ? w_mask   : '0;
  end

  logic w_unused;
  assign w_unused = ^w_occ;

endmodule
